// File: rtl/tc_ram_arbiter.sv
// Round-robin arbiter sharing one single-port 256x8 TC RAM among NUM_REQ masters.
// Optional power-up RAM clear sweep is enabled with `define TC_RAM_ARB_CLEAR_EN.
module tc_ram_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      ram_load,
   output logic                      ram_save,
   output logic [ADDR_W-1:0]         ram_address,
   output logic [DATA_W-1:0]         ram_in,
   input  logic [DATA_W-1:0]         ram_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IW1   = IDX_W + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
`ifdef TC_RAM_ARB_CLEAR_EN
   localparam logic [1:0] CLEAR   = 2'd3;
   localparam logic [1:0] RST_STATE = CLEAR;
`else
   localparam logic [1:0] RST_STATE = IDLE;
`endif

   logic [1:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cur;
   logic             we_q;
   logic [IDX_W-1:0] win;
   logic             found;
   logic [IW1-1:0]   idx;
   logic [IW1-1:0]   nxt;
   logic [IDX_W-1:0] ptr_nxt;

   // Winner is the first requester at or after ptr, wrapping at NUM_REQ.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + IW1'(k);
         if (idx >= IW1'(NUM_REQ)) idx = idx - IW1'(NUM_REQ);
         if (!found && req[idx[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = idx[IDX_W-1:0];
         end
      end
      nxt     = {1'b0, win} + IW1'(1);
      ptr_nxt = (nxt == IW1'(NUM_REQ)) ? '0 : nxt[IDX_W-1:0];
   end

   // NOTE: gnt is combinational so the accept pulse lands in the same IDLE cycle the request is seen.
   always_comb begin
      gnt = '0;
      if (state == IDLE && !rst && found) gnt[win] = 1'b1;
   end

`ifndef TC_RAM_ARB_CLEAR_EN
   assign busy = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: synchronous reset has priority; an in-flight read simply never reaches rvalid.
      if (rst) begin
         state       <= RST_STATE;
         ptr         <= '0;
         cur         <= '0;
         we_q        <= 1'b0;
         rvalid      <= '0;
         rdata       <= '0;
         ram_load    <= 1'b0;
         ram_save    <= 1'b0;
         ram_address <= '0;
         ram_in      <= '0;
`ifdef TC_RAM_ARB_CLEAR_EN
         busy        <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low every cycle and are raised only by the state that owns them.
         rvalid   <= '0;
         ram_load <= 1'b0;
         ram_save <= 1'b0;
         ram_in   <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  cur         <= win;
                  we_q        <= req_we[win];
                  ram_address <= req_addr[win*ADDR_W +: ADDR_W];
                  ram_save    <= req_we[win];
                  ram_load    <= !req_we[win];
                  ram_in      <= req_we[win] ? req_wdata[win*DATA_W +: DATA_W] : '0;
                  ptr         <= ptr_nxt;
                  state       <= ISSUE;
               end
            end
            ISSUE: state <= we_q ? IDLE : CAPTURE;
            CAPTURE: begin
               rdata       <= ram_out;
               rvalid[cur] <= 1'b1;
               state       <= IDLE;
            end
`ifdef TC_RAM_ARB_CLEAR_EN
            CLEAR: begin
               // ram_address doubles as the sweep counter; busy marks that a sweep address is on the pins.
               if (busy && ram_address == '1) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  busy        <= 1'b1;
                  ram_save    <= 1'b1;
                  ram_address <= busy ? ram_address + ADDR_W'(1) : '0;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tc_ram_arbiter.sv
// Randomized scoreboard bench for tc_ram_arbiter with a behavioural RAM and arbitration model.
// Define TC_RAM_ARB_CLEAR_EN to exercise the power-up clear sweep as well.
module tb_tc_ram_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   req_we = '0;
   logic [N*8-1:0] req_addr = '0;
   logic [N*8-1:0] req_wdata = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   rvalid;
   logic [7:0]     rdata;
   logic           busy;
   logic           ram_load;
   logic           ram_save;
   logic [7:0]     ram_address;
   logic [7:0]     ram_in;
   logic [7:0]     ram_out = 8'h00;

   always #5 clk = ~clk;

   tc_ram_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
      .ram_load(ram_load), .ram_save(ram_save), .ram_address(ram_address),
      .ram_in(ram_in), .ram_out(ram_out)
   );

   // Behavioural TC RAM: stores on negedge, registered read that returns 0 when not loading.
   logic [7:0] mem [256];
   always @(negedge clk) if (ram_save) mem[ram_address] <= ram_in;
   always @(posedge clk) ram_out <= ram_load ? mem[ram_address] : 8'h00;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model state
   typedef struct { int idx; logic [7:0] data; int due; } rd_t;
   rd_t        rdq[$];
   logic [7:0] ref_mem [256];
   int         cyc = 0;
   int         next_ok = 0;
   int         ptr_m = 0;
   int         zero_cyc = -1;
   int         clr_lo = -1;
   int         clr_hi = -2;
   bit         iss_v = 0;
   int         iss_cyc = 0;
   bit         iss_we;
   logic [7:0] iss_addr, iss_d;
   logic [N-1:0] seen_gnt = '0;

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'h00;
`ifdef TC_RAM_ARB_CLEAR_EN
         mem[i] = 8'hEE;
`else
         mem[i] = 8'h00;
`endif
      end
   end

   // Monitor / scoreboard
   int           w_m;
   logic [N-1:0] eg;
   bit           in_clr;
   logic [7:0]   a_m, d_m;
   always @(negedge clk) begin
      cyc++;
      seen_gnt = gnt;
      if (rst) begin
         rdq.delete();
         iss_v = 0;
         ptr_m = 0;
         zero_cyc = cyc + 1;
`ifdef TC_RAM_ARB_CLEAR_EN
         clr_lo = cyc + 2;
         clr_hi = cyc + 257;
         next_ok = cyc + 258;
         for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
`else
         next_ok = cyc + 1;
`endif
      end else begin
         in_clr = (cyc >= clr_lo) && (cyc <= clr_hi);
         eg = '0;
         w_m = (cyc >= next_ok) ? rr_pick(req, ptr_m) : -1;
         if (w_m >= 0) eg[w_m] = 1'b1;
         check("gnt", gnt, eg);
         check("busy", busy, in_clr);
         if (iss_v && iss_cyc == cyc) begin
            check("issue_save", ram_save, iss_we);
            check("issue_load", ram_load, !iss_we);
            check("issue_addr", ram_address, iss_addr);
            check("issue_in", ram_in, iss_we ? iss_d : 8'h00);
            iss_v = 0;
         end else if (in_clr) begin
            check("clr_en", {ram_load, ram_save}, 2'b01);
            check("clr_addr", ram_address, 8'(cyc - clr_lo));
            check("clr_in", ram_in, 8'h00);
         end else begin
            check("idle_en", {ram_load, ram_save}, 2'b00);
         end
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            check("rvalid", rvalid, N'(1) << rdq[0].idx);
            check("rdata", rdata, rdq[0].data);
            void'(rdq.pop_front());
         end else begin
            check("rvalid_idle", rvalid, '0);
         end
         if (cyc == zero_cyc) check("post_rst_zero", {rdata, ram_address, ram_in}, 24'h0);
         if (w_m >= 0) begin
            a_m = req_addr[w_m*8 +: 8];
            d_m = req_wdata[w_m*8 +: 8];
            iss_v = 1; iss_cyc = cyc + 1; iss_we = req_we[w_m]; iss_addr = a_m; iss_d = d_m;
            if (req_we[w_m]) begin
               ref_mem[a_m] = d_m;
               next_ok = cyc + 2;
            end else begin
               rdq.push_back('{w_m, ref_mem[a_m], cyc + 3});
               next_ok = cyc + 3;
            end
            ptr_m = (w_m + 1) % N;
         end
      end
   end

   // Driver helpers: inputs change 1 ns after the rising edge; granted requests drop next cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      req = req & ~seen_gnt;
   endtask

   task automatic post(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
      req_we[i] = we;
      req_addr[i*8 +: 8] = a;
      req_wdata[i*8 +: 8] = d;
      req[i] = 1'b1;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      do begin
         tick();
         k++;
      end while ((req != '0 || rdq.size() != 0) && k < limit);
      check("drain_timeout", {31'b0, (req != '0 || rdq.size() != 0)}, 32'd0);
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic logic [7:0] pick_addr();
      int r = $urandom_range(0, 9);
      if (r == 0) return 8'h00;
      if (r == 1) return 8'hFF;
      return 8'h40 + 8'($urandom_range(0, 7));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      wait_done(600);

      // Write then read back through requester 0
      post(0, 1'b1, 8'h10, 8'hA5);
      wait_done(600);
      post(0, 1'b0, 8'h10, 8'h00);
      wait_done(600);

      // All four reading and held high: rotation from ptr 0
      do_reset();
      for (int i = 0; i < N; i++) post(i, 1'b0, 8'h30 + 8'(i), 8'h00);
      repeat (16) begin
         tick();
         for (int i = 0; i < N; i++) if (!req[i]) post(i, 1'b0, 8'h30 + 8'(i), 8'h00);
      end
      wait_done(600);

      // ptr = 1: write by 1 and read by 2 in the same cycle, same address
      do_reset();
      post(0, 1'b1, 8'h21, 8'h11);
      wait_done(600);
      post(1, 1'b1, 8'h20, 8'h3C);
      post(2, 1'b0, 8'h20, 8'h00);
      wait_done(600);

      // Reset during CAPTURE drops the read; the next grant restarts at index 0
      post(0, 1'b0, 8'h10, 8'h00);
      for (int k = 0; k < 20 && req[0]; k++) tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      post(3, 1'b0, 8'h21, 8'h00);
      post(2, 1'b0, 8'h20, 8'h00);
      wait_done(600);

      // Address range ends do not alias
      post(1, 1'b1, 8'hFF, 8'h5A);
      wait_done(600);
      post(3, 1'b1, 8'h00, 8'hC3);
      wait_done(600);
      post(2, 1'b0, 8'hFF, 8'h00);
      post(0, 1'b0, 8'h00, 8'h00);
      wait_done(600);

      // Random mix on a small address pool plus both range ends
      repeat (800) begin
         tick();
         for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(0, 3) == 0)
               post(i, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
      end
      wait_done(600);

`ifdef TC_RAM_ARB_CLEAR_EN
      // Request held across reset exit must wait out the clear sweep
      req = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      post(0, 1'b0, 8'h7E, 8'h00);
      wait_done(600);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
